trakball_emu: RTL and testbench



---
 rtl/trakball_emu.sv | 203 ++++++++++++++++++++
 tb/tb_trakball_emu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trakball_emu.sv
// Joystick-to-trackball emulator: turns direction bits into two 4-bit wrapping
// position counters with per-axis step-rate acceleration.

module trakball_axis #(
  parameter int MAX_PERIOD = 16,
  parameter int MIN_PERIOD = 2,
  parameter int ACCEL_STEP = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       i_tick,
  input  logic       i_reqP,
  input  logic       i_reqN,
  output logic [3:0] o_cnt,
  output logic       o_dir,
  output logic       o_step
);

  localparam logic [7:0] MAX_P = 8'(MAX_PERIOD);
  localparam logic [7:0] MIN_P = 8'(MIN_PERIOD);
  localparam logic [7:0] ACC_P = 8'(ACCEL_STEP);

  typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [3:0] r_cnt;
  logic       r_dir;
  logic       r_step;
  logic [7:0] r_period;
  logic [7:0] r_perCnt;

  logic       w_req;
  logic       w_step;
  logic       w_stepDir;
  logic [7:0] w_periodNext;
  logic [7:0] w_perCntNext;
  logic [8:0] w_perDec;
  logic [7:0] w_periodAcc;

  assign w_req = i_reqP | i_reqN;

  // Nine-bit subtract so a large ACCEL_STEP saturates at MIN_PERIOD instead of wrapping.
  assign w_perDec    = {1'b0, r_period} - {1'b0, ACC_P};
  assign w_periodAcc = (w_perDec[8] || (w_perDec < {1'b0, MIN_P})) ? MIN_P : w_perDec[7:0];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_req)  w_stateNext = MOVE;
      MOVE:    if (!w_req) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // A reversal outranks a due period expiry, so only the new direction steps.
  always_comb begin
    w_step       = 1'b0;
    w_stepDir    = r_dir;
    w_periodNext = r_period;
    w_perCntNext = r_perCnt;
    case (r_state)
      IDLE: begin
        w_periodNext = MAX_P;
        w_perCntNext = 8'd0;
        if (w_req) begin
          w_step    = 1'b1;
          w_stepDir = i_reqP;
        end
      end
      MOVE: begin
        if (!w_req) begin
          w_periodNext = MAX_P;
          w_perCntNext = 8'd0;
        end else if (i_reqP != r_dir) begin
          w_step       = 1'b1;
          w_stepDir    = i_reqP;
          w_periodNext = MAX_P;
          w_perCntNext = 8'd0;
        end else if (i_tick) begin
          if (r_perCnt == (r_period - 8'd1)) begin
            w_step       = 1'b1;
            w_perCntNext = 8'd0;
            w_periodNext = w_periodAcc;
          end else begin
            w_perCntNext = r_perCnt + 8'd1;
          end
        end
      end
      default: begin
        w_periodNext = MAX_P;
        w_perCntNext = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_cnt    <= 4'd0;
      r_dir    <= 1'b0;
      r_step   <= 1'b0;
      r_period <= MAX_P;
      r_perCnt <= 8'd0;
    end else begin
      r_step   <= w_step;
      r_period <= w_periodNext;
      r_perCnt <= w_perCntNext;
      if (w_step) begin
        r_dir <= w_stepDir;
        r_cnt <= w_stepDir ? (r_cnt + 4'd1) : (r_cnt - 4'd1);
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_dir  = r_dir;
  assign o_step = r_step;

endmodule

module trakball_emu #(
  parameter int TICK_DIV   = 12000,
  parameter int MAX_PERIOD = 16,
  parameter int MIN_PERIOD = 2,
  parameter int ACCEL_STEP = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       flip,
  input  logic       h_pos,
  input  logic       h_neg,
  input  logic       v_pos,
  input  logic       v_neg,
  output logic [7:0] trakball_o,
  output logic [1:0] dir_o,
  output logic [1:0] step_o
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_preCnt;
  logic          w_tick;
  logic          w_hp, w_hn, w_vp, w_vn;
  logic [3:0]    w_hCnt, w_vCnt;
  logic          w_hDir, w_vDir, w_hStep, w_vStep;

  // Free-running rate prescaler; presses never resynchronise it.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_preCnt <= '0;
    end else begin
      r_preCnt <= (r_preCnt == PRE_LAST) ? '0 : (r_preCnt + PW'(1));
    end
  end

  assign w_tick = (r_preCnt == PRE_LAST);

  assign w_hp = flip ? h_neg : h_pos;
  assign w_hn = flip ? h_pos : h_neg;
  assign w_vp = flip ? v_neg : v_pos;
  assign w_vn = flip ? v_pos : v_neg;

  trakball_axis #(
    .MAX_PERIOD(MAX_PERIOD), .MIN_PERIOD(MIN_PERIOD), .ACCEL_STEP(ACCEL_STEP)
  ) u_hAxis (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_tick  (w_tick),
    .i_reqP  (w_hp & ~w_hn & enable),
    .i_reqN  (w_hn & ~w_hp & enable),
    .o_cnt   (w_hCnt),
    .o_dir   (w_hDir),
    .o_step  (w_hStep)
  );

  trakball_axis #(
    .MAX_PERIOD(MAX_PERIOD), .MIN_PERIOD(MIN_PERIOD), .ACCEL_STEP(ACCEL_STEP)
  ) u_vAxis (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_tick  (w_tick),
    .i_reqP  (w_vp & ~w_vn & enable),
    .i_reqN  (w_vn & ~w_vp & enable),
    .o_cnt   (w_vCnt),
    .o_dir   (w_vDir),
    .o_step  (w_vStep)
  );

  assign trakball_o = {w_vCnt, w_hCnt};
  assign dir_o      = {w_vDir, w_hDir};
  assign step_o     = {w_vStep, w_hStep};

endmodule

// File: tb/tb_trakball_emu.sv
// Directed testbench for trakball_emu with a fast prescaler (TICK_DIV=4, periods 8..2).

module tb_trakball_emu;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b1;
  logic       flip    = 1'b0;
  logic       h_pos   = 1'b0;
  logic       h_neg   = 1'b0;
  logic       v_pos   = 1'b0;
  logic       v_neg   = 1'b0;
  logic [7:0] trakball_o;
  logic [1:0] dir_o;
  logic [1:0] step_o;

  int total = 0;
  int bad   = 0;

  trakball_emu #(
    .TICK_DIV(4), .MAX_PERIOD(8), .MIN_PERIOD(2), .ACCEL_STEP(2)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .flip       (flip),
    .h_pos      (h_pos),
    .h_neg      (h_neg),
    .v_pos      (v_pos),
    .v_neg      (v_neg),
    .trakball_o (trakball_o),
    .dir_o      (dir_o),
    .step_o     (step_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  // Leaves the bench one step before edge 1 after release, with the prescaler at 0.
  task automatic do_reset();
    enable = 1'b1; flip = 1'b0;
    h_pos = 1'b0; h_neg = 1'b0; v_pos = 1'b0; v_neg = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1; flip = 1'b0;
    h_neg = 1'b0; v_pos = 1'b0; v_neg = 1'b0;
    h_pos = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({trakball_o, dir_o, step_o} !== 12'h000) begin
        bad++;
        $display("[TB] FAIL reset_hold: got tb=%h dir=%b step=%b expected tb=00 dir=00 step=00",
                 trakball_o, dir_o, step_o);
      end
    end
    reset_n = 1'b1;
    cyc();
    total++;
    if (trakball_o !== 8'h01 || dir_o !== 2'b01 || step_o !== 2'b01) begin
      bad++;
      $display("[TB] FAIL reset_first_step: got tb=%h dir=%b step=%b expected tb=01 dir=01 step=01",
               trakball_o, dir_o, step_o);
    end
    repeat (40) cyc();
    reset_n = 1'b0;
    cyc();
    total++;
    if ({trakball_o, dir_o, step_o} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_midmove: got tb=%h dir=%b step=%b expected 00/00/00",
               trakball_o, dir_o, step_o);
    end
    reset_n = 1'b1;
    cyc();
    total++;
    if (trakball_o !== 8'h01 || step_o !== 2'b01) begin
      bad++;
      $display("[TB] FAIL reset_release_idle: got tb=%h step=%b expected tb=01 step=01",
               trakball_o, step_o);
    end
    h_pos = 1'b0;
  endtask

  task automatic test_accel();
    int         lastEdge = 0;
    int         nSteps   = 0;
    int         vSteps   = 0;
    int         expInt;
    logic [3:0] expCnt   = 4'd0;
    do_reset();
    h_pos = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      cyc();
      if (step_o[1]) vSteps++;
      if (step_o[0]) begin
        nSteps++;
        expCnt = expCnt + 4'd1;
        total++;
        if (trakball_o[3:0] !== expCnt) begin
          bad++;
          $display("[TB] FAIL accel_cnt: step %0d got h_cnt=%h expected %h", nSteps, trakball_o[3:0], expCnt);
        end
        if (nSteps == 1) expInt = 1;
        else if (nSteps == 2) expInt = 31;
        else if (nSteps == 3) expInt = 24;
        else if (nSteps == 4) expInt = 16;
        else expInt = 8;
        total++;
        if (i - lastEdge != expInt) begin
          bad++;
          $display("[TB] FAIL accel_interval: step %0d got %0d cycles expected %0d", nSteps, i - lastEdge, expInt);
        end
        lastEdge = i;
      end
    end
    total++;
    if (nSteps != 45) begin
      bad++;
      $display("[TB] FAIL accel_count: got %0d steps expected 45", nSteps);
    end
    total++;
    if (vSteps != 0 || trakball_o[7:4] !== 4'h0 || dir_o !== 2'b01) begin
      bad++;
      $display("[TB] FAIL accel_vaxis: got vsteps=%0d v_cnt=%h dir=%b expected 0/0/01",
               vSteps, trakball_o[7:4], dir_o);
    end
    h_pos = 1'b0;
  endtask

  task automatic test_reversal();
    int seen = 0;
    int gap  = 0;
    do_reset();
    h_pos = 1'b1;
    for (int k = 0; k < 200 && seen < 3; k++) begin
      cyc();
      if (step_o[0]) seen++;
    end
    total++;
    if (seen != 3) begin
      bad++;
      $display("[TB] FAIL rev_setup: got %0d steps expected 3", seen);
    end
    h_pos = 1'b0;
    h_neg = 1'b1;
    cyc();
    total++;
    if (step_o !== 2'b01 || trakball_o !== 8'h02 || dir_o !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rev_switch: got tb=%h dir=%b step=%b expected tb=02 dir=00 step=01",
               trakball_o, dir_o, step_o);
    end
    for (int k = 1; k <= 100 && gap == 0; k++) begin
      cyc();
      if (step_o[0]) gap = k;
    end
    total++;
    if (gap < 29 || gap > 32 || trakball_o !== 8'h01) begin
      bad++;
      $display("[TB] FAIL rev_interval: got gap=%0d tb=%h expected gap 29..32 tb=01", gap, trakball_o);
    end
    h_neg = 1'b0;
  endtask

  task automatic test_conflict_enable();
    int steps = 0;
    do_reset();
    h_pos = 1'b1;
    h_neg = 1'b1;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (step_o != 2'b00) steps++;
    end
    total++;
    if (steps != 0 || trakball_o !== 8'h00) begin
      bad++;
      $display("[TB] FAIL conflict: got steps=%0d tb=%h expected 0/00", steps, trakball_o);
    end
    h_pos = 1'b0; h_neg = 1'b0;
    enable = 1'b0;
    v_neg = 1'b1;
    steps = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (step_o != 2'b00) steps++;
    end
    total++;
    if (steps != 0 || trakball_o !== 8'h00) begin
      bad++;
      $display("[TB] FAIL disabled: got steps=%0d tb=%h expected 0/00", steps, trakball_o);
    end
    enable = 1'b1;
    cyc();
    total++;
    if (step_o !== 2'b10 || trakball_o !== 8'hF0 || dir_o !== 2'b00) begin
      bad++;
      $display("[TB] FAIL enable_rise: got tb=%h dir=%b step=%b expected tb=F0 dir=00 step=10",
               trakball_o, dir_o, step_o);
    end
    v_neg = 1'b0;
  endtask

  task automatic test_flip();
    do_reset();
    flip  = 1'b1;
    v_pos = 1'b1;
    h_neg = 1'b1;
    cyc();
    total++;
    if (trakball_o !== 8'hF1 || dir_o !== 2'b01 || step_o !== 2'b11) begin
      bad++;
      $display("[TB] FAIL flip: got tb=%h dir=%b step=%b expected tb=F1 dir=01 step=11",
               trakball_o, dir_o, step_o);
    end
    flip = 1'b0; v_pos = 1'b0; h_neg = 1'b0;
  endtask

  task automatic test_release_on_tick();
    int steps = 0;
    do_reset();
    h_pos = 1'b1;
    repeat (31) cyc();
    h_pos = 1'b0;
    cyc();
    total++;
    if (step_o !== 2'b00 || trakball_o !== 8'h01) begin
      bad++;
      $display("[TB] FAIL release_tick: got tb=%h step=%b expected tb=01 step=00", trakball_o, step_o);
    end
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (step_o != 2'b00) steps++;
    end
    total++;
    if (steps != 0 || trakball_o !== 8'h01) begin
      bad++;
      $display("[TB] FAIL release_hold: got steps=%0d tb=%h expected 0/01", steps, trakball_o);
    end
    h_pos = 1'b1;
    cyc();
    total++;
    if (step_o !== 2'b01 || trakball_o !== 8'h02) begin
      bad++;
      $display("[TB] FAIL release_idle: got tb=%h step=%b expected tb=02 step=01", trakball_o, step_o);
    end
    h_pos = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accel();
    test_reversal();
    test_conflict_enable();
    test_flip();
    test_release_on_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
